// File: rtl/mnist_cnn_pkg.sv
// Shared MNIST CNN datapath types and constants, used by the dense layer and
// the argmax classifier that consumes its score stream.
package mnist_cnn_pkg;

  localparam int NUM_CLASSES = 10;  // output neurons of the dense layer
  localparam int SCORE_W     = 20;  // signed dense-layer score width
  localparam int CLASS_W     = 4;   // class index width, 2**CLASS_W >= NUM_CLASSES
  localparam int FRAME_CNT_W = 16;

  typedef logic signed [SCORE_W-1:0] score_t;
  typedef logic        [CLASS_W-1:0] class_t;
  typedef logic        [SCORE_W:0]   margin_t;
  typedef logic    [FRAME_CNT_W-1:0] frame_cnt_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } argmax_state_t;

  localparam class_t LAST_CLASS = class_t'(NUM_CLASSES - 1);

  // Distance between the winning and runner-up score. One extra bit keeps the
  // full range of a signed difference, and the result is never negative
  // because hi is always >= lo.
  function automatic margin_t score_margin(input score_t hi, input score_t lo);
    margin_t hi_x;
    margin_t lo_x;
    hi_x = {hi[SCORE_W-1], hi};
    lo_x = {lo[SCORE_W-1], lo};
    return hi_x - lo_x;
  endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational compare-select for the running argmax.
// With FC_ARGMAX_TOP2_EN defined the runner-up (second best) is also tracked.
// Ties always keep the lower (earlier) index: a candidate wins only when it is
// strictly greater.
module argmax_cmp
  import mnist_cnn_pkg::*;
(
  input  logic   first,          // candidate is class 0: take it unconditionally
`ifdef FC_ARGMAX_TOP2_EN
  input  logic   second_first,   // candidate is class 1: runner-up is still empty
  input  score_t second_score,
  input  class_t second_idx,
  output score_t nxt_second_score,
  output class_t nxt_second_idx,
`endif
  input  score_t best_score,
  input  class_t best_idx,
  input  score_t cand_score,
  input  class_t cand_idx,
  output score_t nxt_best_score,
  output class_t nxt_best_idx
);

  logic cand_beats_best;

  // Select the next best (and runner-up) from the current state and candidate.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    cand_beats_best = (cand_score > best_score);  // both score_t: signed compare
    nxt_best_score  = best_score;
    nxt_best_idx    = best_idx;
    if (first || cand_beats_best) begin
      nxt_best_score = cand_score;
      nxt_best_idx   = cand_idx;
    end
`ifdef FC_ARGMAX_TOP2_EN
    nxt_second_score = second_score;
    nxt_second_idx   = second_idx;
    if (first) begin
      // Runner-up has no meaning until class 1 arrives.
      nxt_second_score = cand_score;
      nxt_second_idx   = cand_idx;
    end else if (cand_beats_best) begin
      // Dethroned best becomes the runner-up.
      nxt_second_score = best_score;
      nxt_second_idx   = best_idx;
    end else if (second_first || (cand_score > second_score)) begin
      nxt_second_score = cand_score;
      nxt_second_idx   = cand_idx;
    end
`endif
  end

endmodule

// File: rtl/fc_argmax_classifier.sv
// Final stage of the MNIST CNN datapath: consumes NUM_CLASSES signed scores in
// class order, tracks the running maximum and presents the predicted class
// and its score behind a valid/ready handshake.
// Optional build macro FC_ARGMAX_TOP2_EN adds second_class and margin outputs.
module fc_argmax_classifier
  import mnist_cnn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       valid_in,
  input  score_t     score_in,
  output logic       in_ready,
  output class_t     class_out,
  output score_t     max_score,
`ifdef FC_ARGMAX_TOP2_EN
  output class_t     second_class,
  output margin_t    margin,
`endif
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun_err,
  output frame_cnt_t frame_cnt
);

  argmax_state_t state_q, state_d;
  class_t        idx_q, idx_d;
  score_t        best_score_q, best_score_d;
  class_t        best_idx_q, best_idx_d;
  class_t        class_out_d;
  score_t        max_score_d;
  logic          out_valid_d;
  logic          overrun_err_d;
  frame_cnt_t    frame_cnt_d;

  score_t        cmp_best_score;
  class_t        cmp_best_idx;

`ifdef FC_ARGMAX_TOP2_EN
  score_t        second_score_q, second_score_d;
  class_t        second_idx_q, second_idx_d;
  class_t        second_class_d;
  margin_t       margin_d;
  score_t        cmp_second_score;
  class_t        cmp_second_idx;
`endif

  argmax_cmp u_cmp (
    .first            (idx_q == '0),
`ifdef FC_ARGMAX_TOP2_EN
    .second_first     (idx_q == class_t'(1)),
    .second_score     (second_score_q),
    .second_idx       (second_idx_q),
    .nxt_second_score (cmp_second_score),
    .nxt_second_idx   (cmp_second_idx),
`endif
    .best_score       (best_score_q),
    .best_idx         (best_idx_q),
    .cand_score       (score_in),
    .cand_idx         (idx_q),
    .nxt_best_score   (cmp_best_score),
    .nxt_best_idx     (cmp_best_idx)
  );

  assign in_ready = (state_q == ST_COLLECT);

  // Next-state and next-register logic for the collect/hold controller.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    best_score_d  = best_score_q;
    best_idx_d    = best_idx_q;
    class_out_d   = class_out;
    max_score_d   = max_score;
    out_valid_d   = out_valid;
    overrun_err_d = overrun_err;
    frame_cnt_d   = frame_cnt;
`ifdef FC_ARGMAX_TOP2_EN
    second_score_d = second_score_q;
    second_idx_d   = second_idx_q;
    second_class_d = second_class;
    margin_d       = margin;
`endif

    if (start) begin
      // Abort: partial frame and any pending result are thrown away. A score
      // arriving in the same cycle is dropped silently.
      state_d      = ST_COLLECT;
      idx_d        = '0;
      best_score_d = '0;
      best_idx_d   = '0;
      out_valid_d  = 1'b0;
`ifdef FC_ARGMAX_TOP2_EN
      second_score_d = '0;
      second_idx_d   = '0;
`endif
    end else begin
      unique case (state_q)
        ST_COLLECT: begin
          if (valid_in) begin
            best_score_d = cmp_best_score;
            best_idx_d   = cmp_best_idx;
`ifdef FC_ARGMAX_TOP2_EN
            second_score_d = cmp_second_score;
            second_idx_d   = cmp_second_idx;
`endif
            if (idx_q == LAST_CLASS) begin
              // Last score: publish the compare result including this score.
              class_out_d = cmp_best_idx;
              max_score_d = cmp_best_score;
`ifdef FC_ARGMAX_TOP2_EN
              second_class_d = cmp_second_idx;
              margin_d       = score_margin(cmp_best_score, cmp_second_score);
`endif
              out_valid_d = 1'b1;
              idx_d       = '0;
              frame_cnt_d = frame_cnt + frame_cnt_t'(1);
              state_d     = ST_HOLD;
            end else begin
              idx_d = idx_q + class_t'(1);
            end
          end
        end
        ST_HOLD: begin
          // Scores cannot be taken while a result is pending, even on the
          // handshake cycle itself.
          if (valid_in) begin
            overrun_err_d = 1'b1;
          end
          if (out_valid && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_COLLECT;
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      idx_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      class_out    <= '0;
      max_score    <= '0;
      out_valid    <= 1'b0;
      overrun_err  <= 1'b0;
      frame_cnt    <= '0;
`ifdef FC_ARGMAX_TOP2_EN
      second_score_q <= '0;
      second_idx_q   <= '0;
      second_class   <= '0;
      margin         <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      class_out    <= class_out_d;
      max_score    <= max_score_d;
      out_valid    <= out_valid_d;
      overrun_err  <= overrun_err_d;
      frame_cnt    <= frame_cnt_d;
`ifdef FC_ARGMAX_TOP2_EN
      second_score_q <= second_score_d;
      second_idx_q   <= second_idx_d;
      second_class   <= second_class_d;
      margin         <= margin_d;
`endif
    end
  end

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Self-checking bench for fc_argmax_classifier: a reference model computes the
// expected result of each frame, which is queued when the last score is driven
// and compared when the DUT completes the output handshake.
module tb_fc_argmax_classifier;
  import mnist_cnn_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       valid_in;
  score_t     score_in;
  logic       in_ready;
  class_t     class_out;
  score_t     max_score;
  logic       out_valid;
  logic       out_ready;
  logic       overrun_err;
  frame_cnt_t frame_cnt;
`ifdef FC_ARGMAX_TOP2_EN
  class_t     second_class;
  margin_t    margin;
`endif

  fc_argmax_classifier dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .valid_in    (valid_in),
    .score_in    (score_in),
    .in_ready    (in_ready),
    .class_out   (class_out),
    .max_score   (max_score),
`ifdef FC_ARGMAX_TOP2_EN
    .second_class(second_class),
    .margin      (margin),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun_err (overrun_err),
    .frame_cnt   (frame_cnt)
  );

  typedef struct {
    int cls;
    int score;
    int frames;
    int sec_cls;
    int sec_score;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_frames = 0;

  int f_basic [NUM_CLASSES] = '{5, -3, 100, 7, 0, 0, 0, 0, 0, 99};
  int f_neg   [NUM_CLASSES] = '{-50000, -50000, -50000, -50000, -50000,
                                -50000, -50000, -50000, -50000, -50000};
  int f_tie   [NUM_CLASSES] = '{3, 8, 1, 8, 0, 0, 0, 0, 0, 0};
  int f_edge  [NUM_CLASSES] = '{-524288, 524287, -524288, 524287, 0, 0, 0, 0, 0, 0};
  int f_last  [NUM_CLASSES] = '{-524288, -524288, -524288, -524288, -524288,
                                -524288, -524288, -524288, -524288, -524287};
  int f_hold  [NUM_CLASSES] = '{1, 2, 3, 40, 5, 6, 7, 8, 9, 10};
  int f_max9  [NUM_CLASSES] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 200};
  int f_max6  [NUM_CLASSES] = '{-10, 3, -7, 2, 0, 1, 77, 76, -1, 5};
  int f_part  [NUM_CLASSES] = '{500000, 400000, 1, 2, 3, 4, 5, 6, 7, 8};
  int f_rand  [NUM_CLASSES];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference argmax: strict-greater replaces, ties keep the lower index.
  function automatic exp_t model(input int s[NUM_CLASSES]);
    exp_t e;
    e.cls = 0;
    e.score = s[0];
    e.sec_cls = 0;
    e.sec_score = s[0];
    for (int i = 1; i < NUM_CLASSES; i++) begin
      if (s[i] > e.score) begin
        e.sec_cls = e.cls;
        e.sec_score = e.score;
        e.cls = i;
        e.score = s[i];
      end else if (i == 1 || s[i] > e.sec_score) begin
        e.sec_cls = i;
        e.sec_score = s[i];
      end
    end
    e.frames = 0;
    return e;
  endfunction

  task automatic wait_in_ready();
    for (int c = 0; c < 20 && !in_ready; c++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  // Drive the first n scores of s back-to-back; push the expectation only for
  // a complete frame.
  task automatic send_scores(input int s[NUM_CLASSES], input int n);
    exp_t e;
    wait_in_ready();
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      score_in = score_t'(s[i]);
      if (i == NUM_CLASSES - 1) begin
        e = model(s);
        exp_frames++;
        e.frames = exp_frames & 16'hFFFF;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && sb.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  // Output monitor: compares the oldest expectation on every handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("class_out", int'(class_out), mon_e.cls);
        check("max_score", int'(max_score), mon_e.score);
        check("frame_cnt", int'(frame_cnt), mon_e.frames);
`ifdef FC_ARGMAX_TOP2_EN
        check("second_class", int'(second_class), mon_e.sec_cls);
        check("margin", int'(margin), mon_e.score - mon_e.sec_score);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    valid_in = 1'b0;
    score_in = '0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_class_out", int'(class_out), 0);
    check("rst_max_score", int'(max_score), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_overrun", int'(overrun_err), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame, result accepted immediately: out_valid for one cycle.
    send_scores(f_basic, NUM_CLASSES);
    check("t1_ov_rise", int'(out_valid), 1);
    check("t1_in_ready_hold", int'(in_ready), 0);
    @(posedge clk); #1;
    check("t1_ov_fall", int'(out_valid), 0);
    check("t1_frame_cnt", int'(frame_cnt), 1);
    check("t1_in_ready", int'(in_ready), 1);
    drain();

    send_scores(f_neg, NUM_CLASSES);  drain();
    send_scores(f_tie, NUM_CLASSES);  drain();
    send_scores(f_edge, NUM_CLASSES); drain();
    send_scores(f_last, NUM_CLASSES); drain();
    check("no_overrun_yet", int'(overrun_err), 0);

    // Back-pressure: result held and stable, scores dropped and flagged.
    out_ready = 1'b0;
    send_scores(f_hold, NUM_CLASSES);
    for (int i = 0; i < 5; i++) begin
      valid_in = (i % 2 == 0);
      score_in = score_t'(1000 + i);
      @(posedge clk); #1;
      check("hold_out_valid", int'(out_valid), 1);
      check("hold_class_out", int'(class_out), sb[0].cls);
      check("hold_max_score", int'(max_score), sb[0].score);
      check("hold_in_ready", int'(in_ready), 0);
    end
    valid_in = 1'b0;
    check("overrun_set", int'(overrun_err), 1);
    out_ready = 1'b1;
    drain();
    send_scores(f_max9, NUM_CLASSES); drain();
    check("overrun_sticky", int'(overrun_err), 1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NUM_CLASSES; i++)
        f_rand[i] = int'($urandom_range(0, 1048575)) - 524288;
      send_scores(f_rand, NUM_CLASSES);
      drain();
    end

    // Asynchronous reset mid-frame.
    send_scores(f_basic, 7);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_class_out", int'(class_out), 0);
    check("mid_rst_max_score", int'(max_score), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_overrun", int'(overrun_err), 0);
    check("mid_rst_frame_cnt", int'(frame_cnt), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    exp_frames = 0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send_scores(f_basic, NUM_CLASSES); drain();
    check("post_rst_frame_cnt", int'(frame_cnt), 1);

    // start while a result is pending: result discarded, count kept, no flag.
    out_ready = 1'b0;
    send_scores(f_tie, NUM_CLASSES);
    start = 1'b1;
    valid_in = 1'b1;
    score_in = score_t'(77);
    @(posedge clk); #1;
    start = 1'b0;
    valid_in = 1'b0;
    void'(sb.pop_back());
    check("disc_out_valid", int'(out_valid), 0);
    check("disc_frame_cnt", int'(frame_cnt), exp_frames);
    check("disc_overrun", int'(overrun_err), 0);
    check("disc_in_ready", int'(in_ready), 1);
    out_ready = 1'b1;

    // start after 4 scores, colliding with a score that must be dropped.
    send_scores(f_part, 4);
    start = 1'b1;
    valid_in = 1'b1;
    score_in = score_t'(524287);
    @(posedge clk); #1;
    start = 1'b0;
    valid_in = 1'b0;
    send_scores(f_max6, NUM_CLASSES); drain();
    check("start_frame_cnt", int'(frame_cnt), exp_frames);
    check("start_no_overrun", int'(overrun_err), 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty_end", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
